// File: rtl/vec_cache_rd_resp_collect.sv
// Read-response collector: eight per-lane FIFOs fed by the memory-block chain,
// drained round-robin into a single registered response stage.
package vec_cache_pkg;
  typedef enum logic [1:0] {
    VEC_CACHE_NOP      = 2'd0,
    VEC_CACHE_READ     = 2'd1,
    VEC_CACHE_WRITE    = 2'd2,
    VEC_CACHE_LINEFILL = 2'd3
  } vec_cache_op_e;

  typedef struct packed {
    logic [7:0]    txnid;
    vec_cache_op_e opcode;
    logic [3:0]    byte_sel;
    logic [1:0]    dest_ram_id;
  } sram_inst_cmd_t;

  typedef struct packed {
    logic [31:0]    data;
    sram_inst_cmd_t cmd_pld;
  } data_pld_t;
endpackage

module vec_cache_rd_resp_collect
  import vec_cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BLOCK_NUM  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_in_vld,
  input  data_pld_t [7:0]      data_in,
  output logic                 resp_vld,
  input  logic                 resp_rdy,
  output data_pld_t            resp_pld,
  output logic [2:0]           resp_lane,
  output logic [7:0]           lane_afull,
  output logic [7:0]           ovf_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BLOCK_NUM < 1) begin : g_param_check
    $error("vec_cache_rd_resp_collect: bad FIFO_DEPTH or BLOCK_NUM");
  end

  data_pld_t      mem    [8][FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr [8];
  logic [PW-1:0]  rd_ptr [8];
  logic [CW-1:0]  cnt    [8];
  logic [2:0]     rr_ptr;

  logic [7:0] push_req, full, nonempty, pop, accept;
  logic       load, grant_vld;
  logic [2:0] grant, idx;

  assign load = !resp_vld || resp_rdy;

  // Per-lane status decode from the registered counts.
  always_comb begin
    push_req   = 8'd0;
    full       = 8'd0;
    nonempty   = 8'd0;
    lane_afull = 8'd0;
    for (int i = 0; i < 8; i++) begin
      push_req[i]   = data_in_vld[i] && (data_in[i].cmd_pld.opcode == VEC_CACHE_READ);
      full[i]       = (cnt[i] == CW'(FIFO_DEPTH));
      nonempty[i]   = (cnt[i] != '0);
      lane_afull[i] = (cnt[i] >= CW'(FIFO_DEPTH - 1));
    end
  end

  // Round-robin search upward from rr_ptr+1; k=8 wraps back onto rr_ptr itself.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 3'd0;
    idx       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = rr_ptr + 3'(k);
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

  // Pop/accept decode; a full lane can still take a beat when it pops the same cycle.
  always_comb begin
    pop    = 8'd0;
    accept = 8'd0;
    for (int i = 0; i < 8; i++) begin
      pop[i]    = load && grant_vld && (grant == 3'(i));
      accept[i] = push_req[i] && (!full[i] || pop[i]);
    end
  end

  // FIFO storage, not reset: validity is tracked by the counts alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (accept[i]) begin
        mem[i][wr_ptr[i]] <= data_in[i];
      end
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({accept[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Output register, arbitration pointer and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld  <= 1'b0;
      resp_pld  <= '0;
      resp_lane <= 3'd0;
      rr_ptr    <= 3'd7;
      ovf_err   <= 8'd0;
    end else begin
      ovf_err <= ovf_err | (push_req & full & ~pop);
      if (load) begin
        resp_vld <= grant_vld;
        if (grant_vld) begin
          resp_pld  <= mem[grant][rd_ptr[grant]];
          resp_lane <= grant;
          rr_ptr    <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_cache_rd_resp_collect.sv
// Directed self-checking bench for vec_cache_rd_resp_collect.
module tb_vec_cache_rd_resp_collect;
  import vec_cache_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      data_in_vld = 8'd0;
  data_pld_t [7:0] data_in = '0;
  logic            resp_vld;
  logic            resp_rdy = 1'b0;
  data_pld_t       resp_pld;
  logic [2:0]      resp_lane;
  logic [7:0]      lane_afull;
  logic [7:0]      ovf_err;

  int tests  = 0;
  int failed = 0;

  vec_cache_rd_resp_collect #(.FIFO_DEPTH(4), .BLOCK_NUM(4)) dut (
    .clk(clk), .rst(rst), .data_in_vld(data_in_vld), .data_in(data_in),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_pld(resp_pld),
    .resp_lane(resp_lane), .lane_afull(lane_afull), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic data_pld_t mk(input logic [31:0] d, input vec_cache_op_e op);
    data_pld_t p;
    p = '0;
    p.data = d;
    p.cmd_pld.opcode = op;
    p.cmd_pld.txnid = d[7:0];
    return p;
  endfunction

  task automatic clear_in();
    data_in_vld = 8'd0;
    data_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    resp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (resp_vld !== 1'b0) begin failed++; $display("FAIL reset_vld got %0b exp 0", resp_vld); end
    tests++; if (resp_pld !== '0) begin failed++; $display("FAIL reset_pld got %h exp 0", resp_pld); end
    tests++; if (resp_lane !== 3'd0) begin failed++; $display("FAIL reset_lane got %0d exp 0", resp_lane); end
    tests++; if (lane_afull !== 8'd0) begin failed++; $display("FAIL reset_afull got %h exp 00", lane_afull); end
    tests++; if (ovf_err !== 8'd0) begin failed++; $display("FAIL reset_ovf got %h exp 00", ovf_err); end
  endtask

  task automatic test_single();
    int extra;
    do_reset();
    resp_rdy = 1'b1;
    data_in_vld[3] = 1'b1;
    data_in[3] = mk(32'hDEADBEEF, VEC_CACHE_READ);
    @(posedge clk); #1 clear_in();
    tests++; if (resp_vld !== 1'b0) begin failed++; $display("FAIL single_early got vld %0b exp 0", resp_vld); end
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b1 || resp_pld.data !== 32'hDEADBEEF || resp_lane !== 3'd3) begin
      failed++; $display("FAIL single_beat got vld %0b data %h lane %0d exp 1 deadbeef 3", resp_vld, resp_pld.data, resp_lane);
    end
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (resp_vld) extra++; end
    tests++; if (extra !== 0) begin failed++; $display("FAIL single_extra got %0d beats exp 0", extra); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_lane [3];
    exp_lane = '{3'd0, 3'd2, 3'd5};
    do_reset();
    resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in_vld[exp_lane[i]] = 1'b1;
      data_in[exp_lane[i]] = mk(32'h100 + 32'(exp_lane[i]), VEC_CACHE_READ);
    end
    @(posedge clk); #1 clear_in();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (resp_vld !== 1'b1 || resp_lane !== exp_lane[i] || resp_pld.data !== 32'h100 + 32'(exp_lane[i])) begin
        failed++; $display("FAIL fair_%0d got vld %0b lane %0d data %h exp lane %0d", i, resp_vld, resp_lane, resp_pld.data, exp_lane[i]);
      end
    end
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b0) begin failed++; $display("FAIL fair_tail got vld %0b exp 0", resp_vld); end
  endtask

  task automatic test_filter();
    int seen;
    do_reset();
    resp_rdy = 1'b1;
    data_in_vld[1] = 1'b1;
    data_in[1] = mk(32'h0000_0A0A, VEC_CACHE_WRITE);
    @(posedge clk); #1;
    data_in[1] = mk(32'h0000_0B0B, VEC_CACHE_LINEFILL);
    @(posedge clk); #1 clear_in();
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (resp_vld) seen++; end
    tests++; if (seen !== 0) begin failed++; $display("FAIL filter_resp got %0d beats exp 0", seen); end
    tests++; if (ovf_err !== 8'd0 || lane_afull !== 8'd0) begin
      failed++; $display("FAIL filter_flags got ovf %h afull %h exp 00 00", ovf_err, lane_afull);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    resp_rdy = 1'b0;
    data_in_vld[0] = 1'b1;
    data_in[0] = mk(32'hAAAA0000, VEC_CACHE_READ);
    @(posedge clk); #1 clear_in();
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b1 || resp_lane !== 3'd0) begin
      failed++; $display("FAIL ovf_preload got vld %0b lane %0d exp 1 0", resp_vld, resp_lane);
    end
    for (int k = 1; k <= 5; k++) begin
      data_in_vld[6] = 1'b1;
      data_in[6] = mk(32'(k), VEC_CACHE_READ);
      @(posedge clk); #1 clear_in();
      tests++; if (lane_afull[6] !== (k >= 3) || ovf_err[6] !== (k == 5)) begin
        failed++; $display("FAIL ovf_push%0d got afull %0b ovf %0b exp %0b %0b", k, lane_afull[6], ovf_err[6], k >= 3, k == 5);
      end
    end
    resp_rdy = 1'b1;
    tests++; if (resp_pld.data !== 32'hAAAA0000) begin failed++; $display("FAIL ovf_hold got %h exp aaaa0000", resp_pld.data); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      tests++; if (resp_vld !== 1'b1 || resp_lane !== 3'd6 || resp_pld.data !== 32'(k)) begin
        failed++; $display("FAIL ovf_drain%0d got vld %0b lane %0d data %h exp 1 6 %h", k, resp_vld, resp_lane, resp_pld.data, k);
      end
    end
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b0) begin failed++; $display("FAIL ovf_beat5 got vld %0b data %h exp 0", resp_vld, resp_pld.data); end
    tests++; if (ovf_err !== 8'h40) begin failed++; $display("FAIL ovf_sticky got %h exp 40", ovf_err); end
  endtask

  task automatic test_stall();
    logic [2:0]  exp_lane [5];
    logic [31:0] exp_data [5];
    exp_lane = '{3'd2, 3'd4, 3'd0, 3'd2, 3'd4};
    exp_data = '{32'h20, 32'h40, 32'h01, 32'h21, 32'h41};
    do_reset();
    resp_rdy = 1'b0;
    data_in_vld[1] = 1'b1;
    data_in[1] = mk(32'h11, VEC_CACHE_READ);
    @(posedge clk); #1 clear_in();
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      if (c < 2) begin
        data_in_vld[2] = 1'b1; data_in[2] = mk(32'h20 + 32'(c), VEC_CACHE_READ);
        data_in_vld[4] = 1'b1; data_in[4] = mk(32'h40 + 32'(c), VEC_CACHE_READ);
      end else if (c == 2) begin
        data_in_vld[0] = 1'b1; data_in[0] = mk(32'h01, VEC_CACHE_READ);
      end
      @(posedge clk); #1 clear_in();
      tests++; if (resp_vld !== 1'b1 || resp_lane !== 3'd1 || resp_pld.data !== 32'h11) begin
        failed++; $display("FAIL stall_c%0d got vld %0b lane %0d data %h exp 1 1 11", c, resp_vld, resp_lane, resp_pld.data);
      end
    end
    resp_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      tests++; if (resp_vld !== 1'b1 || resp_lane !== exp_lane[j] || resp_pld.data !== exp_data[j]) begin
        failed++; $display("FAIL stall_rr%0d got lane %0d data %h exp lane %0d data %h", j, resp_lane, resp_pld.data, exp_lane[j], exp_data[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    resp_rdy = 1'b0;
    data_in_vld = 8'b0010_1010;
    data_in[1] = mk(32'h1111, VEC_CACHE_READ);
    data_in[3] = mk(32'h3333, VEC_CACHE_READ);
    data_in[5] = mk(32'h5555, VEC_CACHE_READ);
    @(posedge clk); #1 clear_in();
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b1 || resp_lane !== 3'd1) begin
      failed++; $display("FAIL mid_pre got vld %0b lane %0d exp 1 1", resp_vld, resp_lane);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (resp_vld !== 1'b0 || resp_pld !== '0 || resp_lane !== 3'd0) begin
      failed++; $display("FAIL mid_async got vld %0b pld %h lane %0d exp 0 0 0", resp_vld, resp_pld, resp_lane);
    end
    @(posedge clk); #1 rst = 1'b0;
    resp_rdy = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_vld) seen++; end
    tests++; if (seen !== 0) begin failed++; $display("FAIL mid_stale got %0d beats exp 0", seen); end
    data_in_vld[2] = 1'b1;
    data_in[2] = mk(32'h2222, VEC_CACHE_READ);
    @(posedge clk); #1 clear_in();
    @(posedge clk); #1;
    tests++; if (resp_vld !== 1'b1 || resp_lane !== 3'd2 || resp_pld.data !== 32'h2222) begin
      failed++; $display("FAIL mid_after got vld %0b lane %0d data %h exp 1 2 2222", resp_vld, resp_lane, resp_pld.data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_filter();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
